// File: rtl/vio_route_stage_pkg.sv
// Shared stream widths and route-stage types for the vio switch datapath.
package lynxTypes;

  localparam int unsigned AXI_DATA_BITS = 64;
  localparam int unsigned AXI_KEEP_BITS = AXI_DATA_BITS / 8;
  localparam int unsigned PID_BITS      = 6;
  localparam int unsigned ROUTE_BITS    = 14;

  typedef enum logic [1:0] {
    RT_IDLE,
    RT_FWD,
    RT_DROP
  } route_state_t;

endpackage

// File: rtl/vio_route_stage_if.sv
// AXI4 stream bundle carrying data, byte keep, last and packet id.
interface AXI4SR;
  import lynxTypes::*;

  logic                     tvalid;
  logic                     tready;
  logic [AXI_DATA_BITS-1:0] tdata;
  logic [AXI_KEEP_BITS-1:0] tkeep;
  logic                     tlast;
  logic [PID_BITS-1:0]      tid;

  modport s (input tvalid, tdata, tkeep, tlast, tid, output tready);
  modport m (output tvalid, tdata, tkeep, tlast, tid, input tready);
endinterface

// File: rtl/vio_route_stage_skid.sv
// Two-entry skid buffer; reports next-cycle room so the producer can register its ready.
module route_skid_buf #(
  parameter int unsigned  W          = 8,
  parameter logic [W-1:0] RESET_WORD = '0
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         room_next,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid, skid_valid_nx, out_valid_nx;
  logic [W-1:0] skid_data, skid_data_nx, out_data_nx;

  // push is only issued while the skid slot is empty, so no beat can be lost here
  always_comb begin
    out_valid_nx  = out_valid;
    out_data_nx   = out_data;
    skid_valid_nx = skid_valid;
    skid_data_nx  = skid_data;
    if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid_nx  = 1'b1;
        out_data_nx   = skid_data;
        skid_valid_nx = 1'b0;
      end else if (push) begin
        out_valid_nx = 1'b1;
        out_data_nx  = push_data;
      end else begin
        out_valid_nx = 1'b0;
      end
    end else if (push) begin
      skid_valid_nx = 1'b1;
      skid_data_nx  = push_data;
    end
  end

  assign room_next = !skid_valid_nx;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_valid  <= 1'b0;
      out_data   <= RESET_WORD;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      out_valid  <= out_valid_nx;
      out_data   <= out_data_nx;
      skid_valid <= skid_valid_nx;
      skid_data  <= skid_data_nx;
    end
  end

endmodule

// File: rtl/vio_route_stage.sv
// Tags each user packet with a route word latched at its first beat, or discards it.
module vio_route_stage
  import lynxTypes::*;
#(
  parameter int unsigned           ROUTE_BITS    = lynxTypes::ROUTE_BITS,
  parameter logic [ROUTE_BITS-1:0] ROUTE_DEFAULT = '0,
  parameter logic [ROUTE_BITS-1:0] ROUTE_DROP    = '1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ROUTE_BITS-1:0] route_cfg,
  input  logic                  route_cfg_valid,
  AXI4SR.s                      data_sink,
  AXI4SR.m                      data_src,
  output logic [ROUTE_BITS-1:0] route_out,
  output logic [31:0]           pkt_fwd_cnt,
  output logic [31:0]           pkt_drop_cnt
);

  localparam int unsigned BEAT_W = AXI_DATA_BITS + AXI_KEEP_BITS + 1 + PID_BITS + ROUTE_BITS;

  route_state_t          state, state_nx;
  logic [ROUTE_BITS-1:0] pending, active, beat_route;
  logic                  sink_ready, accept, first_beat, drop_beat, push, room_next;
  logic [BEAT_W-1:0]     push_word, out_word;
  logic [31:0]           fwd_cnt, drop_cnt;

  assign accept     = data_sink.tvalid && sink_ready;
  assign first_beat = (state == RT_IDLE);
  // the first beat uses pending directly: active only catches up at that same edge
  assign beat_route = first_beat ? pending : active;
  assign drop_beat  = (state == RT_DROP) || (first_beat && pending == ROUTE_DROP);
  assign push       = accept && !drop_beat;
  assign push_word  = {data_sink.tdata, data_sink.tkeep, data_sink.tlast, data_sink.tid, beat_route};

  always_comb begin
    state_nx = state;
    case (state)
      RT_IDLE: if (accept && !data_sink.tlast) state_nx = drop_beat ? RT_DROP : RT_FWD;
      RT_FWD,
      RT_DROP: if (accept && data_sink.tlast) state_nx = RT_IDLE;
      default: state_nx = RT_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= RT_IDLE;
      pending    <= ROUTE_DEFAULT;
      active     <= ROUTE_DEFAULT;
      sink_ready <= 1'b0;
      fwd_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (route_cfg_valid) pending <= route_cfg;
      if (accept && first_beat) active <= pending;
      sink_ready <= room_next || (state_nx == RT_DROP);
      if (data_src.tvalid && data_src.tready && data_src.tlast) fwd_cnt <= fwd_cnt + 32'd1;
      if (accept && drop_beat && data_sink.tlast) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  route_skid_buf #(
    .W          (BEAT_W),
    .RESET_WORD (BEAT_W'(ROUTE_DEFAULT))
  ) u_skid (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (push),
    .push_data (push_word),
    .room_next (room_next),
    .out_valid (data_src.tvalid),
    .out_ready (data_src.tready),
    .out_data  (out_word)
  );

  assign {data_src.tdata, data_src.tkeep, data_src.tlast, data_src.tid, route_out} = out_word;
  assign data_sink.tready = sink_ready;
  assign pkt_fwd_cnt      = fwd_cnt;
  assign pkt_drop_cnt     = drop_cnt;

endmodule

// File: tb/tb_vio_route_stage.sv
// Scoreboard bench for vio_route_stage: driver queues expected beats, monitor checks outputs.
`timescale 1ns/1ps
module tb_vio_route_stage;
  import lynxTypes::*;

  localparam int unsigned    RB   = 14;
  localparam logic [RB-1:0]  DEF  = '0;
  localparam logic [RB-1:0]  DROP = '1;

  typedef struct {
    logic [AXI_DATA_BITS-1:0] data;
    logic [AXI_KEEP_BITS-1:0] keep;
    logic                     last;
    logic [PID_BITS-1:0]      id;
    logic [RB-1:0]            route;
    int                       acc_cyc;
    bit                       chk_lat;
  } exp_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [RB-1:0] route_cfg = '0;
  logic          route_cfg_valid = 1'b0;
  logic [RB-1:0] route_out;
  logic [31:0]   pkt_fwd_cnt, pkt_drop_cnt;

  AXI4SR sink_if ();
  AXI4SR src_if ();

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   rnd_ready = 1'b0;
  bit   lat_mode = 1'b0;

  vio_route_stage #(
    .ROUTE_BITS    (RB),
    .ROUTE_DEFAULT (DEF),
    .ROUTE_DROP    (DROP)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .route_cfg       (route_cfg),
    .route_cfg_valid (route_cfg_valid),
    .data_sink       (sink_if),
    .data_src        (src_if),
    .route_out       (route_out),
    .pkt_fwd_cnt     (pkt_fwd_cnt),
    .pkt_drop_cnt    (pkt_drop_cnt)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  always @(posedge aclk) begin
    #1;
    src_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: handshake seen at the negedge completes at the following posedge.
  always @(negedge aclk) begin
    if (!aresetn) begin
      q.delete();
    end else if (src_if.tvalid && src_if.tready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got data=%h route=%h, expected no output beat", src_if.tdata, route_out);
      end else begin
        mon_e = q.pop_front();
        n_checks++;
        if (src_if.tdata !== mon_e.data || src_if.tkeep !== mon_e.keep || src_if.tlast !== mon_e.last ||
            src_if.tid !== mon_e.id || route_out !== mon_e.route) begin
          n_fail++;
          $display("FAIL beat: got data=%h keep=%h last=%b id=%h route=%h, expected data=%h keep=%h last=%b id=%h route=%h",
                   src_if.tdata, src_if.tkeep, src_if.tlast, src_if.tid, route_out,
                   mon_e.data, mon_e.keep, mon_e.last, mon_e.id, mon_e.route);
        end
        if (mon_e.chk_lat) check("latency", 64'(cyc), 64'(mon_e.acc_cyc + 1));
      end
    end
  end

  task automatic strobe(input logic [RB-1:0] val);
    route_cfg       = val;
    route_cfg_valid = 1'b1;
    @(posedge aclk); #1;
    route_cfg_valid = 1'b0;
  endtask

  // Sends n beats; abort_at >= 0 leaves that beat presented and returns without waiting.
  task automatic send_pkt(input int n, input logic [RB-1:0] exp_route, input bit drop, input int tag,
                          input int strobe_beat, input logic [RB-1:0] strobe_val, input int abort_at);
    exp_t e;
    int   w;
    for (int i = 0; i < n; i++) begin
      sink_if.tdata   = {32'(tag), 32'(i) ^ 32'hA5A5_0000};
      sink_if.tkeep   = (i % 2 == 1) ? 8'h0F : 8'hFF;
      sink_if.tlast   = (i == n - 1);
      sink_if.tid     = 6'(tag);
      sink_if.tvalid  = 1'b1;
      route_cfg_valid = (i == strobe_beat);
      if (i == strobe_beat) route_cfg = strobe_val;
      if (i == abort_at) return;
      w = 0;
      do begin
        @(negedge aclk);
        w++;
      end while (!sink_if.tready && w < 200);
      if (!sink_if.tready) begin
        n_checks++;
        n_fail++;
        $display("FAIL sink_ready_timeout: got tready=0 after %0d cycles, expected tready=1", w);
      end else if (drop) begin
        check("drop_tready_immediate", 64'(w), 64'd1);
      end else begin
        e.data = sink_if.tdata; e.keep = sink_if.tkeep; e.last = sink_if.tlast;
        e.id = sink_if.tid; e.route = exp_route; e.acc_cyc = cyc; e.chk_lat = lat_mode;
        q.push_back(e);
      end
      @(posedge aclk); #1;
    end
    sink_if.tvalid  = 1'b0;
    sink_if.tlast   = 1'b0;
    route_cfg_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    do begin
      @(negedge aclk);
      w++;
    end while ((q.size() != 0 || src_if.tvalid) && w < 400);
    check("drain_queue_empty", 64'(q.size()), 64'd0);
    check("drain_tvalid_low", 64'(src_if.tvalid), 64'd0);
    @(posedge aclk); #1;
  endtask

  initial begin
    sink_if.tvalid = 1'b0; sink_if.tdata = '0; sink_if.tkeep = '0;
    sink_if.tlast = 1'b0;  sink_if.tid = '0;   src_if.tready = 1'b1;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_tvalid", 64'(src_if.tvalid), 64'd0);
    check("rst_sink_tready", 64'(sink_if.tready), 64'd0);
    check("rst_route_out", 64'(route_out), 64'(DEF));
    check("rst_fwd_cnt", 64'(pkt_fwd_cnt), 64'd0);
    check("rst_drop_cnt", 64'(pkt_drop_cnt), 64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); @(negedge aclk);
    check("release_sink_tready", 64'(sink_if.tready), 64'd1);
    @(posedge aclk); #1;

    // 4-beat packet on route 5, one-cycle latency per beat
    strobe(14'h0005);
    lat_mode = 1'b1;
    send_pkt(4, 14'h0005, 1'b0, 1, -1, '0, -1);
    drain();
    lat_mode = 1'b0;
    check("fwd_cnt_t1", 64'(pkt_fwd_cnt), 64'd1);

    // mid-packet strobe, then strobe coinciding with a first beat
    send_pkt(6, 14'h0005, 1'b0, 2, 1, 14'h0003, -1);
    send_pkt(2, 14'h0003, 1'b0, 3, 0, 14'h0007, -1);
    send_pkt(1, 14'h0007, 1'b0, 4, -1, '0, -1);
    drain();
    check("fwd_cnt_t2", 64'(pkt_fwd_cnt), 64'd4);

    // dropped packets: multi-beat and single-beat
    strobe(DROP);
    send_pkt(3, DROP, 1'b1, 5, -1, '0, -1);
    send_pkt(1, DROP, 1'b1, 6, -1, '0, -1);
    drain();
    check("drop_cnt", 64'(pkt_drop_cnt), 64'd2);
    check("fwd_cnt_after_drop", 64'(pkt_fwd_cnt), 64'd4);

    // 100 packets of random length under random output backpressure
    rnd_ready = 1'b1;
    for (int p = 0; p < 100; p++) begin
      strobe(RB'(p + 16));
      send_pkt(int'($urandom_range(1, 16)), RB'(p + 16), 1'b0, 100 + p, -1, '0, -1);
    end
    drain();
    rnd_ready = 1'b0;
    check("fwd_cnt_random", 64'(pkt_fwd_cnt), 64'd104);

    // reset while beat 3 of an 8-beat packet is presented
    strobe(14'h0009);
    send_pkt(8, 14'h0009, 1'b0, 200, -1, '0, 2);
    aresetn = 1'b0;
    sink_if.tvalid = 1'b0;
    @(posedge aclk); @(negedge aclk);
    check("midrst_tvalid", 64'(src_if.tvalid), 64'd0);
    check("midrst_fwd_cnt", 64'(pkt_fwd_cnt), 64'd0);
    check("midrst_drop_cnt", 64'(pkt_drop_cnt), 64'd0);
    check("midrst_route_out", 64'(route_out), 64'(DEF));
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); @(negedge aclk);
    check("midrst_release_tready", 64'(sink_if.tready), 64'd1);
    @(posedge aclk); #1;
    send_pkt(5, DEF, 1'b0, 201, -1, '0, -1);
    drain();
    check("fwd_cnt_after_midrst", 64'(pkt_fwd_cnt), 64'd1);

    // forwarded-packet counter wraps to zero
    force dut.fwd_cnt = 32'hFFFF_FFFF;
    @(posedge aclk); #1;
    release dut.fwd_cnt;
    @(negedge aclk);
    check("fwd_cnt_preload", 64'(pkt_fwd_cnt), 64'hFFFF_FFFF);
    @(posedge aclk); #1;
    send_pkt(3, DEF, 1'b0, 202, -1, '0, -1);
    drain();
    check("fwd_cnt_wrap", 64'(pkt_fwd_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL global_timeout: got no completion by %0t, expected test end", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
